debug_btn_conditioner: RTL and testbench



---
 rtl/debug_pkg.sv | 21 ++
 rtl/debug_btn_channel.sv | 134 +++++++++++++
 rtl/debug_btn_conditioner.sv | 49 ++++
 tb/tb_debug_btn_conditioner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// ---------------------------------------------------------------------------
// debug_pkg
// Shared types and default timing constants for the debug button path.
//   btn_state_t        : per-channel debounce FSM state
//   DEF_DEBOUNCE_CYCLES: 10 ms at the 27 MHz board clock
//   DEF_LONG_CYCLES    : 500 ms at the 27 MHz board clock
// ---------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BOARD_CLK_HZ        = 27_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = BOARD_CLK_HZ / 100;  // 10 ms
    localparam int DEF_LONG_CYCLES     = BOARD_CLK_HZ / 2;    // 500 ms

endpackage

// File: rtl/debug_btn_channel.sv
// ---------------------------------------------------------------------------
// debug_btn_channel
// One button channel: 2-flop synchroniser, debounce FSM, optional hold
// counter for long-press detection. All outputs are registered.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   raw_i      raw pin, asynchronous to clk_i
//   level_o    debounced state, 1 = pressed
//   press_o    1-cycle pulse when a press is accepted
//   release_o  1-cycle pulse when a release is accepted
//   long_o     1-cycle pulse once per press after LONG_CYCLES held
// ---------------------------------------------------------------------------
module debug_btn_channel
    import debug_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int             DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    // Synchroniser holds the raw pin value; released level is 1 when active-low.
    localparam logic [1:0]     SYNC_REL = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    btn_state_t    state_q;
    logic [1:0]    sync_q;
    logic [DW-1:0] deb_cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          s;

    // Pressed-polarity view of the synchronised pin.
    assign s = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= SYNC_REL;
            state_q   <= RELEASED;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        deb_cnt_q <= '0;
                        state_q   <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= RELEASED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        deb_cnt_q <= '0;
                        state_q   <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q <= PRESSED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q   <= RELEASED;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                default: state_q <= RELEASED;
            endcase
        end
    end

    generate
        if (LONG_CYCLES > 0) begin : g_long
            localparam int            HW       = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

            logic [HW-1:0] hold_cnt_q;
            logic          long_q;

            // Counts cycles spent in PRESSED only, so a bounce into
            // RELEASE_WAIT freezes the count and a return resumes it.
            // Clearing throughout PRESS_WAIT yields 0 on press acceptance.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    hold_cnt_q <= '0;
                    long_q     <= 1'b0;
                end else begin
                    long_q <= 1'b0;
                    if (state_q == PRESS_WAIT) begin
                        hold_cnt_q <= '0;
                    end else if (state_q == PRESSED && hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                        if (hold_cnt_q == HOLD_MAX - 1'b1) long_q <= 1'b1;
                    end
                end
            end

            assign long_o = long_q;
        end else begin : g_no_long
            assign long_o = 1'b0;
        end
    endgenerate

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/debug_btn_conditioner.sv
// ---------------------------------------------------------------------------
// debug_btn_conditioner
// Synchronises and debounces the debug push buttons and produces clean
// levels plus single-cycle press / release / long-press events.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw      raw button pins (index 0 = btnA, 1 = btnB)
//   btn_level    debounced state, 1 = pressed
//   btn_press    1-cycle pulse on accepted press
//   btn_release  1-cycle pulse on accepted release
//   btn_long     1-cycle pulse once per press after LONG_CYCLES held
// ---------------------------------------------------------------------------
module debug_btn_conditioner
    import debug_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
            debug_btn_channel #(
                .ACTIVE_LOW      (ACTIVE_LOW),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES)
            ) u_ch (
                .clk_i     (clk),
                .rst_i     (rst),
                .raw_i     (btn_raw[i]),
                .level_o   (btn_level[i]),
                .press_o   (btn_press[i]),
                .release_o (btn_release[i]),
                .long_o    (btn_long[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debug_btn_conditioner.sv
module tb_debug_btn_conditioner;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '1;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

    debug_btn_conditioner #(
        .NUM_BTN(NB), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pressed-polarity sample stream delayed two edges,
    // a "disagreement run" per channel (consecutive samples that differ
    // from the accepted level; D+1 of them flips the level), and a
    // stable-pressed cycle count for long-press.
    bit          m_s1 [NB];
    bit          m_s2 [NB];
    bit          m_lvl[NB];
    int          m_run[NB];
    int          m_hold[NB];
    logic [NB-1:0] e_lvl, e_prs, e_rel, e_lng;

    task automatic model_step(input logic [NB-1:0] r, input logic rs);
        e_prs = '0; e_rel = '0; e_lng = '0;
        for (int c = 0; c < NB; c++) begin
            if (rs) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_hold[c] = 0;
            end else begin
                bit s;
                s = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = ~r[c];
                if (m_lvl[c] && m_run[c] == 0 && m_hold[c] < L) begin
                    m_hold[c]++;
                    if (m_hold[c] == L) e_lng[c] = 1'b1;
                end
                if (s != m_lvl[c]) m_run[c]++;
                else               m_run[c] = 0;
                if (m_run[c] == D + 1) begin
                    m_run[c] = 0;
                    m_lvl[c] = s;
                    if (s) begin e_prs[c] = 1'b1; m_hold[c] = 0; end
                    else         e_rel[c] = 1'b1;
                end
            end
            e_lvl[c] = m_lvl[c];
        end
    endtask

    // One clock: drive inputs away from the edge, step the model at the
    // edge, compare just after it.
    task automatic tick(input logic [NB-1:0] r, input logic rs);
        btn_raw = r;
        rst     = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        chk("level",   btn_level,   e_lvl);
        chk("press",   btn_press,   e_prs);
        chk("release", btn_release, e_rel);
        chk("long",    btn_long,    e_lng);
        if ((btn_press & btn_release) != '0) chk("press_and_release", btn_press & btn_release, '0);
    endtask

    int press_edge, long_edge;
    logic [NB-1:0] raw_v;
    int seg[NB];

    initial begin
        // Reset state
        model_step(2'b11, 1'b1);
        #1;
        chk("rst_level", btn_level, '0);
        chk("rst_press", btn_press, '0);
        chk("rst_long",  btn_long,  '0);
        for (int i = 0; i < 3; i++) tick(2'b11, 1'b1);
        #3;

        // Clean press on btnA: press at edge 7, long at edge 17
        press_edge = 0; long_edge = 0;
        for (int e = 1; e <= 22; e++) begin
            tick(2'b10, 1'b0);
            if (btn_press[0] && press_edge == 0) press_edge = e;
            if (btn_long[0]  && long_edge  == 0) long_edge  = e;
        end
        chk("s1_press_edge", press_edge, 7);
        chk("s1_long_edge",  long_edge,  17);
        for (int i = 0; i < 10; i++) tick(2'b11, 1'b0);

        // Bounce rejection, then held
        for (int i = 0; i < 3; i++) tick(2'b10, 1'b0);
        for (int i = 0; i < 2; i++) tick(2'b11, 1'b0);
        press_edge = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(2'b10, 1'b0);
            if (btn_press[0] && press_edge == 0) press_edge = e;
        end
        chk("s2_press_edge", press_edge, 7);
        // Release bounce while held: long still fires from frozen count
        for (int i = 0; i < 2; i++) tick(2'b11, 1'b0);
        for (int i = 0; i < 15; i++) tick(2'b10, 1'b0);
        for (int i = 0; i < 12; i++) tick(2'b11, 1'b0);

        // Simultaneous buttons, release only btnB
        for (int i = 0; i < 9; i++) tick(2'b00, 1'b0);
        for (int i = 0; i < 9; i++) tick(2'b01, 1'b0);
        for (int i = 0; i < 9; i++) tick(2'b11, 1'b0);

        // Reset mid PRESS_WAIT with button held
        for (int i = 0; i < 4; i++) tick(2'b10, 1'b0);
        for (int i = 0; i < 3; i++) tick(2'b10, 1'b1);
        press_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            tick(2'b10, 1'b0);
            if (btn_press[0] && press_edge == 0) press_edge = e;
        end
        chk("s6_press_edge", press_edge, 7);
        for (int i = 0; i < 10; i++) tick(2'b11, 1'b0);

        // Randomised segments of held levels per channel, occasional reset
        raw_v = '1;
        for (int c = 0; c < NB; c++) seg[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (seg[c] == 0) begin
                    raw_v[c] = ~raw_v[c];
                    seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(1, 22);
                end
                seg[c]--;
            end
            if ($urandom_range(0, 299) == 0) begin
                for (int k = 0; k < 2; k++) tick(raw_v, 1'b1);
            end else begin
                tick(raw_v, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
